// File: rtl/fetch_npc_unit_if.sv
// IF-stage / IF-ID boundary bundle: D-stage redirect controls, IM interface and IF/ID outputs.
// The master side drives control and fetch data; the slave (fetch unit) returns pc_F and IF/ID state.
interface fetch_npc_unit_if;
  logic        stall;
  logic [1:0]  npc_op;
  logic        b_jump;
  logic        br_likely;
  logic [15:0] imm16_D;
  logic [25:0] imm26_D;
  logic [31:0] rs_D;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        adel_D;

  modport master (
    output stall, npc_op, b_jump, br_likely, imm16_D, imm26_D, rs_D, instr_F,
    input  pc_F, instr_D, pc_D, pc8_D, adel_D
  );

  modport slave (
    input  stall, npc_op, b_jump, br_likely, imm16_D, imm26_D, rs_D, instr_F,
    output pc_F, instr_D, pc_D, pc8_D, adel_D
  );
endinterface

// File: rtl/fetch_npc_unit.sv
// MIPS IF stage: next-PC selection, PC register and IF/ID pipeline register with
// stall, branch-likely delay-slot nullification and fetch address-error flagging.
module fetch_npc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input logic            clk,
  input logic            reset,
  fetch_npc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_J      = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_e;

  localparam logic [31:0] IM_LIMIT = PC_RESET + 32'(IM_WORDS * 4);

  npc_op_e     npc_op;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc8_q, ifid_pc8_d;
  logic        ifid_adel_q, ifid_adel_d;

  logic [31:0] pc_plus4;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] pc_next;
  logic        adel_f;
  logic        nullify;

  assign npc_op        = npc_op_e'(bus.npc_op);
  assign pc_plus4      = pc_q + 32'd4;
  assign ifid_pc_plus4 = ifid_pc_q + 32'd4;
  assign br_offset     = {{14{bus.imm16_D[15]}}, bus.imm16_D, 2'b00};

  // Fetch proceeds even on a bad address; the word is squashed to a nop and flagged for D.
  assign adel_f = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || (pc_q >= IM_LIMIT);

  // Only a not-taken branch-likely kills its delay slot.
  assign nullify = (npc_op == NPC_BRANCH) && bus.br_likely && !bus.b_jump;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    pc_next = pc_plus4;
    case (npc_op)
      NPC_PC4:    pc_next = pc_plus4;
      NPC_BRANCH: pc_next = bus.b_jump ? (ifid_pc_plus4 + br_offset) : pc_plus4;
      NPC_J:      pc_next = {ifid_pc_plus4[31:28], bus.imm26_D, 2'b00};
      NPC_JR:     pc_next = bus.rs_D;
      default:    pc_next = pc_plus4;
    endcase
  end

  // A stall holds everything and discards the redirect; it is re-evaluated once the stall clears.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc8_d   = ifid_pc8_q;
    ifid_adel_d  = ifid_adel_q;
    if (!bus.stall) begin
      pc_d       = pc_next;
      ifid_pc_d  = pc_q;
      ifid_pc8_d = pc_q + 32'd8;
      if (nullify) begin
        ifid_instr_d = 32'd0;
        ifid_adel_d  = 1'b0;
      end else begin
        ifid_instr_d = adel_f ? 32'd0 : bus.instr_F;
        ifid_adel_d  = adel_f;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= PC_RESET;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_pc8_q   <= 32'd0;
      ifid_adel_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc8_q   <= ifid_pc8_d;
      ifid_adel_q  <= ifid_adel_d;
    end
  end

  assign bus.pc_F    = pc_q;
  assign bus.instr_D = ifid_instr_q;
  assign bus.pc_D    = ifid_pc_q;
  assign bus.pc8_D   = ifid_pc8_q;
  assign bus.adel_D  = ifid_adel_q;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Scoreboard bench for fetch_npc_unit: directed vectors push hand-computed post-edge
// state into a queue; a negedge monitor pops and compares.
module tb_fetch_npc_unit;

  logic clk;
  logic reset;

  fetch_npc_unit_if bus ();

  fetch_npc_unit #(
    .PC_RESET(32'h0000_3000),
    .IM_WORDS(4096)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected post-edge state per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.name, ".pc_F"},    bus.pc_F,    mon_e.pc);
      check({mon_e.name, ".instr_D"}, bus.instr_D, mon_e.instr);
      check({mon_e.name, ".pc_D"},    bus.pc_D,    mon_e.pcd);
      check({mon_e.name, ".pc8_D"},   bus.pc8_D,   mon_e.pc8);
      check({mon_e.name, ".adel_D"},  {31'd0, bus.adel_D}, {31'd0, mon_e.adel});
    end
  end

  // Drive one cycle of inputs, queue the expected state after the next edge.
  task automatic step(input string nm, input logic st, input logic [1:0] op,
                      input logic bj, input logic bl, input logic [15:0] i16,
                      input logic [25:0] i26, input logic [31:0] rs, input logic [31:0] ins,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pcd, input logic [31:0] e_pc8, input logic e_adel);
    exp_t e;
    bus.stall     = st;
    bus.npc_op    = op;
    bus.b_jump    = bj;
    bus.br_likely = bl;
    bus.imm16_D   = i16;
    bus.imm26_D   = i26;
    bus.rs_D      = rs;
    bus.instr_F   = ins;
    e.name  = nm;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pcd   = e_pcd;
    e.pc8   = e_pc8;
    e.adel  = e_adel;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, ".pc_F"},    bus.pc_F,    32'h0000_3000);
    check({nm, ".instr_D"}, bus.instr_D, 32'd0);
    check({nm, ".pc_D"},    bus.pc_D,    32'd0);
    check({nm, ".pc8_D"},   bus.pc8_D,   32'd0);
    check({nm, ".adel_D"},  {31'd0, bus.adel_D}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] PC4 = 2'd0, BR = 2'd1, JMP = 2'd2, JR = 2'd3;

  initial begin
    reset         = 1'b0;
    bus.stall     = 1'b0;
    bus.npc_op    = PC4;
    bus.b_jump    = 1'b0;
    bus.br_likely = 1'b0;
    bus.imm16_D   = 16'd0;
    bus.imm26_D   = 26'd0;
    bus.rs_D      = 32'd0;
    bus.instr_F   = 32'd0;

    @(negedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;

    //   name        st op  bj bl imm16     imm26       rs            instr          pc_F          instr_D        pc_D          pc8_D      adel
    step("seq1",     0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0001, 32'h3004, 32'hA000_0001, 32'h3000, 32'h3008, 0);
    step("seq2",     0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0002, 32'h3008, 32'hA000_0002, 32'h3004, 32'h300C, 0);
    step("seq3",     0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0003, 32'h300C, 32'hA000_0003, 32'h3008, 32'h3010, 0);
    step("seq4",     0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0004, 32'h3010, 32'hA000_0004, 32'h300C, 32'h3014, 0);
    step("seq5",     0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0005, 32'h3014, 32'hA000_0005, 32'h3010, 32'h3018, 0);
    // Taken backward branch from pc_D=3010, then not-taken falls through.
    step("br_tk",    0, BR,  1, 0, 16'hFFFE, 26'h0, 32'h0,          32'hA000_0006, 32'h300C, 32'hA000_0006, 32'h3014, 32'h301C, 0);
    step("br_nt",    0, BR,  0, 0, 16'hFFFE, 26'h0, 32'h0,          32'hA000_0007, 32'h3010, 32'hA000_0007, 32'h300C, 32'h3014, 0);
    // Two stalled cycles with b_jump toggling hold all state; release redirects once.
    step("stall1",   1, BR,  1, 0, 16'h0010, 26'h0, 32'h0,          32'hA000_0008, 32'h3010, 32'hA000_0007, 32'h300C, 32'h3014, 0);
    step("stall2",   1, BR,  0, 1, 16'h0010, 26'h0, 32'h0,          32'hA000_0009, 32'h3010, 32'hA000_0007, 32'h300C, 32'h3014, 0);
    step("unstall",  0, BR,  1, 0, 16'h0010, 26'h0, 32'h0,          32'hA000_000A, 32'h3050, 32'hA000_000A, 32'h3010, 32'h3018, 0);
    step("post_st",  0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_000B, 32'h3054, 32'hA000_000B, 32'h3050, 32'h3058, 0);
    // JR to a misaligned address: fetch proceeds, D gets nop + adel.
    step("jr_mis",   0, JR,  0, 0, 16'h0000, 26'h0, 32'h0000_3002, 32'hA000_000C, 32'h3002, 32'hA000_000C, 32'h3054, 32'h305C, 0);
    step("adel1",    0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_000D, 32'h3006, 32'h0000_0000, 32'h3002, 32'h300A, 1);
    step("adel2",    0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_000E, 32'h300A, 32'h0000_0000, 32'h3006, 32'h300E, 1);
    step("jr_base",  0, JR,  0, 0, 16'h0000, 26'h0, 32'h0000_3000, 32'hA000_000F, 32'h3000, 32'h0000_0000, 32'h300A, 32'h3012, 1);
    step("seq16",    0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0010, 32'h3004, 32'hA000_0010, 32'h3000, 32'h3008, 0);
    // J with pc_D=3000: {(3004)[31:28], 0000C04, 00} = 3010.
    step("j",        0, JMP, 0, 0, 16'h0000, 26'h0000C04, 32'h0,    32'hA000_0011, 32'h3010, 32'hA000_0011, 32'h3004, 32'h300C, 0);
    // Branch-likely: not taken nullifies the delay slot, taken keeps it.
    step("bl_nt",    0, BR,  0, 1, 16'h0000, 26'h0, 32'h0,          32'h2408_0001, 32'h3014, 32'h0000_0000, 32'h3010, 32'h3018, 0);
    step("bl_tk",    0, BR,  1, 1, 16'h0004, 26'h0, 32'h0,          32'h2408_0001, 32'h3024, 32'h2408_0001, 32'h3014, 32'h301C, 0);
    // Range boundaries: 7000 is one past the last word, 6FFC is the last word, 2FFC is below base.
    step("jr_hi",    0, JR,  0, 0, 16'h0000, 26'h0, 32'h0000_7000, 32'hA000_0014, 32'h7000, 32'hA000_0014, 32'h3024, 32'h302C, 0);
    step("jr_last",  0, JR,  0, 0, 16'h0000, 26'h0, 32'h0000_6FFC, 32'hA000_0015, 32'h6FFC, 32'h0000_0000, 32'h7000, 32'h7008, 1);
    step("last_ok",  0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0016, 32'h7000, 32'hA000_0016, 32'h6FFC, 32'h7004, 0);
    step("jr_lo",    0, JR,  0, 0, 16'h0000, 26'h0, 32'h0000_2FFC, 32'hA000_0017, 32'h2FFC, 32'h0000_0000, 32'h7000, 32'h7008, 1);
    step("lo_bad",   0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0018, 32'h3000, 32'h0000_0000, 32'h2FFC, 32'h3004, 1);
    step("base_ok",  0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,          32'hA000_0019, 32'h3004, 32'hA000_0019, 32'h3000, 32'h3008, 0);
    step("jr_3020",  0, JR,  0, 0, 16'h0000, 26'h0, 32'h0000_3020, 32'hA000_001A, 32'h3020, 32'hA000_001A, 32'h3004, 32'h300C, 0);

    // Asynchronous reset between edges takes effect with no clock edge.
    bus.npc_op = PC4;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    #1;
    reset = 1'b1;
    step("after_rst", 0, PC4, 0, 0, 16'h0000, 26'h0, 32'h0,         32'hA000_001B, 32'h3004, 32'hA000_001B, 32'h3000, 32'h3008, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- IF-stage program counter plus IF/ID pipeline register for the 5-stage MIPS core.
- Consumes the D-stage branch decision (b_jump) from the comparator, the control unit's next-PC select, and the forwarded rs value.
- Selects and registers the next PC and drives the instruction-memory address.
- Latches the fetched instruction, PC and link address into D; handles stall, branch-likely delay-slot nullification and fetch address errors.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; base of instruction memory.
- IM_WORDS, 4096, instruction-memory size in words; valid fetch range is [PC_RESET, PC_RESET+4*IM_WORDS).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- stall  input  1  hazard-unit stall; holds PC and IF/ID register.
- npc_op  input  2  next-PC select from D-stage control: 0 PC4, 1 BRANCH, 2 J, 3 JR.
- b_jump  input  1  branch condition from comparator, valid when npc_op=BRANCH.
- br_likely  input  1  D-stage instruction is a branch-likely.
- imm16_D  input  16  branch offset field of D-stage instruction.
- imm26_D  input  26  jump index field of D-stage instruction.
- rs_D  input  32  forwarded rs value for JR/JALR.
- instr_F  input  32  instruction word from IM at pc_F.
- pc_F  output  32  current fetch address to IM.
- instr_D  output  32  IF/ID instruction.
- pc_D  output  32  IF/ID PC.
- pc8_D  output  32  IF/ID link address (pc+8).
- adel_D  output  1  IF/ID fetch-address-error flag.

Behaviour:
- Reset (asynchronous, reset=0): pc_F=PC_RESET, instr_D=0, pc_D=0, pc8_D=0, adel_D=0. Effective immediately, independent of clk. First fetch at PC_RESET on the first edge after release.
- Next-PC (combinational, all arithmetic modulo 2^32, wrap allowed):
  - PC4: pc_F+4.
  - BRANCH & b_jump: pc_D+4+(sign_extend(imm16_D)<<2).
  - BRANCH & !b_jump: pc_F+4.
  - J: {pc_D[31:28]+carry-free from pc_D+4, i.e. (pc_D+4)[31:28], imm26_D, 2'b00}.
  - JR: rs_D unchanged.
- Rising edge, stall=1: pc_F and all IF/ID outputs hold; npc_op/b_jump ignored that cycle (operands may be unforwarded).
- Rising edge, stall=0:
  - pc_F <= next-PC.
  - IF/ID loads pc_D<=pc_F, pc8_D<=pc_F+8, adel_D<=adel_F, instr_D<=(adel_F ? 0 : instr_F).
- adel_F (internal, combinational): pc_F[1:0]!=0 or pc_F outside valid range. Fetch still proceeds; the word is replaced with nop (0). No trap is taken here.
- Delay slot: the instruction after a branch/jump always executes.
  - Exception: when npc_op=BRANCH, br_likely=1, b_jump=0 and stall=0, IF/ID loads instr_D=0 and adel_D=0. pc_D and pc8_D still load pc_F and pc_F+8 (delay slot nullified).
- Simultaneous events: reset > stall > nullify > normal load. Stall with a pending branch defers the decision until the stall clears; no decision is stored internally.
- Latency: one cycle from an npc_op/b_jump decision to the new pc_F.

Test Plan:
- Release reset, npc_op=0, no stall, 3 edges -> pc_F 3000,3004,3008,300C; pc_D 3000,3004,3008; pc8_D 3008,300C,3010.
- pc_D=3010, npc_op=BRANCH, b_jump=1, imm16=FFFE -> next pc_F=300C; with b_jump=0 and pc_F=3014 -> next pc_F=3018.
- stall=1 for 2 cycles during BRANCH with b_jump toggling -> pc_F, instr_D, pc_D unchanged. Stall drops with b_jump=1 -> single redirect to the target.
- npc_op=JR, rs_D=00003002 -> pc_F=3002. Next edge -> adel_D=1, instr_D=0. npc_op=J, imm26=0000C04, pc_D=3000 -> pc_F=3010.
- br_likely=1, BRANCH, b_jump=0, instr_F=24080001 -> instr_D=0, pc_D=delay-slot PC. Same with b_jump=1 -> instr_D=24080001.
- Assert reset mid-stream (between edges, pc_F=3020) -> pc_F=3000 and instr_D=0 immediately, without a clock edge.
